// File: rtl/dyt_mem_arbiter_if.sv
// Requester and SRAM-side signal bundle for dyt_mem_arbiter.
// The arbiter takes the slave view; the fetch/memory stages plus the SRAM take the master view.
interface dyt_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              i_ren;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic [31:0]       i_rdata;

   logic              d_ren;
   logic              d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [1:0]        d_size;
   logic              d_unsigned;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_err;
   logic [31:0]       d_rdata;

   logic [ADDR_W-3:0] sram_addr;
   logic              sram_ren;
   logic              sram_wen;
   logic [3:0]        sram_be;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   modport slave (
      input  i_ren, i_addr,
      input  d_ren, d_wen, d_addr, d_size, d_unsigned, d_wdata,
      input  sram_rdata,
      output i_gnt, i_rdata,
      output d_gnt, d_err, d_rdata,
      output sram_addr, sram_ren, sram_wen, sram_be, sram_wdata
   );

   modport master (
      output i_ren, i_addr,
      output d_ren, d_wen, d_addr, d_size, d_unsigned, d_wdata,
      output sram_rdata,
      input  i_gnt, i_rdata,
      input  d_gnt, d_err, d_rdata,
      input  sram_addr, sram_ren, sram_wen, sram_be, sram_wdata
   );
endinterface

// File: rtl/dyt_mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous SRAM with byte-lane stores,
// sign/zero-extended sub-word loads and misalignment errors. READ_LAT must be 1..4.
module dyt_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 2,
   parameter int FAIR     = 1
) (
   input  logic               clk,
   input  logic               n_rst,
   dyt_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_DONE = 2'd2,
      ERR     = 2'd3
   } state_t;

   localparam bit       FAIR_EN  = (FAIR != 0);
   localparam logic [1:0] CNT_LOAD = 2'(READ_LAT - 1);

   state_t            state_reg;
   logic [1:0]        cnt_reg;
   logic              last_d_reg;
   logic              owner_d_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        size_reg;
   logic              unsigned_reg;

   logic              idle_act;
   logic              d_req;
   logic              pick_d;
   logic              pick_i;
   logic              misalign;
   logic              wr_issue;
   logic              rd_issue;
   logic              rd_done;
   logic [1:0]        off;
   logic [ADDR_W-3:0] win_waddr;
   logic [3:0]        be_vec;
   logic [31:0]       wdata_vec;
   logic [31:0]       shifted;
   logic [31:0]       load_ext;
   logic              unused_ok;

   // Issue logic is gated by n_rst so every strobe drops the moment reset asserts.
   assign idle_act  = (state_reg == IDLE) && n_rst;
   assign d_req     = bus.d_ren | bus.d_wen;
   assign pick_d    = idle_act && d_req && !(FAIR_EN && last_d_reg && bus.i_ren);
   assign pick_i    = idle_act && bus.i_ren && !pick_d;
   assign off       = bus.d_addr[1:0];
   assign misalign  = ((bus.d_size == 2'b01) && off[0]) || (bus.d_size[1] && (off != 2'b00));
   assign wr_issue  = pick_d && !misalign && bus.d_wen;
   assign rd_issue  = (pick_d && !misalign && !bus.d_wen) || pick_i;
   assign rd_done   = (state_reg == RD_WAIT) && (cnt_reg == 2'd0);
   assign win_waddr = pick_d ? bus.d_addr[ADDR_W-1:2] : bus.i_addr[ADDR_W-1:2];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 2'd0;
         last_d_reg   <= 1'b0;
         owner_d_reg  <= 1'b0;
         addr_reg     <= '0;
         size_reg     <= 2'b00;
         unsigned_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_d || pick_i) begin
                  addr_reg     <= pick_d ? bus.d_addr : bus.i_addr;
                  size_reg     <= pick_d ? bus.d_size : 2'b10;
                  unsigned_reg <= pick_d & bus.d_unsigned;
                  owner_d_reg  <= pick_d;
                  if (pick_d && misalign) begin
                     state_reg <= ERR;
                  end else if (pick_d && bus.d_wen) begin
                     state_reg <= WR_DONE;
                  end else begin
                     state_reg <= RD_WAIT;
                     cnt_reg   <= CNT_LOAD;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt_reg == 2'd0) begin
                  state_reg  <= IDLE;
                  last_d_reg <= owner_d_reg;
               end else begin
                  cnt_reg <= cnt_reg - 2'd1;
               end
            end
            WR_DONE, ERR: begin
               state_reg  <= IDLE;
               last_d_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-lane store steering: the selected lanes all carry the same right-justified datum.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic       lane_sel;
         logic [7:0] lane_byte;

         always_comb begin
            lane_sel  = 1'b1;
            lane_byte = bus.d_wdata[8*gi +: 8];
            case (bus.d_size)
               2'b00: begin
                  lane_sel  = (off == 2'(gi));
                  lane_byte = bus.d_wdata[7:0];
               end
               2'b01: begin
                  lane_sel  = (off[1] == 1'(gi / 2));
                  lane_byte = bus.d_wdata[8*(gi % 2) +: 8];
               end
               default: begin
                  lane_sel  = 1'b1;
                  lane_byte = bus.d_wdata[8*gi +: 8];
               end
            endcase
         end

         assign be_vec[gi]          = wr_issue & lane_sel;
         assign wdata_vec[8*gi +: 8] = wr_issue ? lane_byte : 8'h00;
      end
   endgenerate

   assign shifted = bus.sram_rdata >> {addr_reg[1:0], 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_reg)
         2'b00:   load_ext = unsigned_reg ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = unsigned_reg ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   assign bus.sram_ren   = rd_issue;
   assign bus.sram_wen   = wr_issue;
   assign bus.sram_be    = be_vec;
   assign bus.sram_wdata = wdata_vec;
   assign bus.sram_addr  = (rd_issue || wr_issue)  ? win_waddr :
                           (state_reg == RD_WAIT)  ? addr_reg[ADDR_W-1:2] : '0;

   assign bus.i_gnt   = rd_done && !owner_d_reg;
   assign bus.i_rdata = (rd_done && !owner_d_reg) ? bus.sram_rdata : 32'h0;
   assign bus.d_gnt   = (rd_done && owner_d_reg) || (state_reg == WR_DONE) || (state_reg == ERR);
   assign bus.d_err   = (state_reg == ERR);
   assign bus.d_rdata = (rd_done && owner_d_reg) ? load_ext : 32'h0;

   // Instruction fetches are always whole words.
   assign unused_ok = ^bus.i_addr[1:0];

endmodule

// File: tb/tb_dyt_mem_arbiter.sv
// Directed bench: DUT A (READ_LAT=2, FAIR=1) and DUT B (READ_LAT=4, FAIR=0), each with a behavioural SRAM.
module tb_dyt_mem_arbiter;

   logic clk;
   logic n_rst;
   int   n_checks;
   int   n_errors;

   dyt_mem_arbiter_if #(.ADDR_W(32)) bus_a ();
   dyt_mem_arbiter_if #(.ADDR_W(32)) bus_b ();

   dyt_mem_arbiter #(.ADDR_W(32), .READ_LAT(2), .FAIR(1)) u_dut_a (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_a)
   );

   dyt_mem_arbiter #(.ADDR_W(32), .READ_LAT(4), .FAIR(0)) u_dut_b (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAMs: byte-enabled writes, read data appears READ_LAT cycles after ren.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pipe_a [2];
   logic [31:0] pipe_b [4];

   assign bus_a.sram_rdata = pipe_a[1];
   assign bus_b.sram_rdata = pipe_b[3];

   always @(posedge clk) begin
      if (!n_rst) begin
         mem_a[8'h10] <= 32'hDEADBEEF;
         mem_a[8'h20] <= 32'h11111111;
         mem_a[8'h21] <= 32'h22222222;
         mem_a[8'h40] <= 32'h12345678;
         mem_b[8'h30] <= 32'h33333333;
         mem_b[8'h31] <= 32'h44444444;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bus_a.sram_wen && bus_a.sram_be[b])
               mem_a[bus_a.sram_addr[7:0]][8*b +: 8] <= bus_a.sram_wdata[8*b +: 8];
            if (bus_b.sram_wen && bus_b.sram_be[b])
               mem_b[bus_b.sram_addr[7:0]][8*b +: 8] <= bus_b.sram_wdata[8*b +: 8];
         end
      end
      pipe_a[0] <= bus_a.sram_ren ? mem_a[bus_a.sram_addr[7:0]] : 32'h0BAD0BAD;
      pipe_a[1] <= pipe_a[0];
      pipe_b[0] <= bus_b.sram_ren ? mem_b[bus_b.sram_addr[7:0]] : 32'h0BAD0BAD;
      for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One data transaction on DUT A from issue (cycle 0) through the grant and one idle cycle.
   task automatic a_data(input string tag, input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic exp_ren, input logic exp_wen, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_err, input logic [31:0] exp_rdata,
                         input int lat);
      tick();
      bus_a.d_wen      = wen;
      bus_a.d_ren      = ren;
      bus_a.d_addr     = addr;
      bus_a.d_size     = size;
      bus_a.d_unsigned = uns;
      bus_a.d_wdata    = wdata;
      @(negedge clk);
      chk({tag, "_ren"}, {31'h0, bus_a.sram_ren}, {31'h0, exp_ren});
      chk({tag, "_wen"}, {31'h0, bus_a.sram_wen}, {31'h0, exp_wen});
      chk({tag, "_gnt_c0"}, {31'h0, bus_a.d_gnt}, 32'h0);
      if (!exp_err) chk({tag, "_addr"}, {2'b00, bus_a.sram_addr}, {2'b00, addr[31:2]});
      if (exp_wen) begin
         chk({tag, "_be"}, {28'h0, bus_a.sram_be}, {28'h0, exp_be});
         chk({tag, "_wdata"}, bus_a.sram_wdata, exp_wdata);
      end
      for (int c = 1; c <= lat; c++) begin
         tick();
         @(negedge clk);
         chk({tag, "_gnt"}, {31'h0, bus_a.d_gnt}, {31'h0, 1'(c == lat)});
         chk({tag, "_quiet"}, {31'h0, bus_a.sram_ren | bus_a.sram_wen}, 32'h0);
      end
      chk({tag, "_err"}, {31'h0, bus_a.d_err}, {31'h0, exp_err});
      chk({tag, "_rdata"}, bus_a.d_rdata, exp_rdata);
      tick();
      bus_a.d_wen = 1'b0;
      bus_a.d_ren = 1'b0;
      @(negedge clk);
      chk({tag, "_after"}, {30'h0, bus_a.d_gnt, bus_a.sram_wen}, 32'h0);
      $display("txn %s done", tag);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      n_rst    = 1'b0;
      bus_a.i_ren = 1'b0; bus_a.i_addr = '0; bus_a.d_ren = 1'b0; bus_a.d_wen = 1'b0;
      bus_a.d_addr = '0; bus_a.d_size = 2'b00; bus_a.d_unsigned = 1'b0; bus_a.d_wdata = '0;
      bus_b.i_ren = 1'b0; bus_b.i_addr = '0; bus_b.d_ren = 1'b0; bus_b.d_wen = 1'b0;
      bus_b.d_addr = '0; bus_b.d_size = 2'b00; bus_b.d_unsigned = 1'b0; bus_b.d_wdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnts", {28'h0, bus_a.i_gnt, bus_a.d_gnt, bus_a.d_err, bus_b.d_gnt}, 32'h0);
      chk("rst_strobes", {28'h0, bus_a.sram_ren, bus_a.sram_wen, bus_b.sram_ren, bus_b.sram_wen}, 32'h0);
      chk("rst_be", {28'h0, bus_a.sram_be}, 32'h0);
      chk("rst_rdata", bus_a.i_rdata | bus_a.d_rdata | bus_b.d_rdata, 32'h0);
      $display("txn reset done");
      tick();
      n_rst = 1'b1;

      // Instruction read, READ_LAT=2.
      tick();
      bus_a.i_ren = 1'b1; bus_a.i_addr = 32'h40;
      @(negedge clk);
      chk("ird_ren", {31'h0, bus_a.sram_ren}, 32'h1);
      chk("ird_addr", {2'b00, bus_a.sram_addr}, 32'h10);
      tick(); @(negedge clk);
      chk("ird_c1_gnt", {31'h0, bus_a.i_gnt}, 32'h0);
      chk("ird_c1_addr", {2'b00, bus_a.sram_addr}, 32'h10);
      tick(); @(negedge clk);
      chk("ird_c2_gnt", {31'h0, bus_a.i_gnt}, 32'h1);
      chk("ird_rdata", bus_a.i_rdata, 32'hDEADBEEF);
      chk("ird_dgnt", {31'h0, bus_a.d_gnt}, 32'h0);
      tick(); bus_a.i_ren = 1'b0; @(negedge clk);
      chk("ird_c3_idle", {30'h0, bus_a.i_gnt, bus_a.sram_ren}, 32'h0);
      $display("txn ird done");

      // Contested rounds, FAIR=1: d, i, d, i.
      tick();
      bus_a.i_ren = 1'b1; bus_a.i_addr = 32'h80;
      bus_a.d_ren = 1'b1; bus_a.d_addr = 32'h84; bus_a.d_size = 2'b10; bus_a.d_unsigned = 1'b0;
      @(negedge clk);
      chk("fair_r1_win_d", {2'b00, bus_a.sram_addr}, 32'h21);
      tick(); tick(); @(negedge clk);
      chk("fair_r1_dgnt", {30'h0, bus_a.d_gnt, bus_a.i_gnt}, 32'h2);
      chk("fair_r1_drdata", bus_a.d_rdata, 32'h22222222);
      tick(); @(negedge clk);
      chk("fair_r2_win_i", {2'b00, bus_a.sram_addr}, 32'h20);
      tick(); tick(); @(negedge clk);
      chk("fair_r2_igng", {30'h0, bus_a.d_gnt, bus_a.i_gnt}, 32'h1);
      chk("fair_r2_irdata", bus_a.i_rdata, 32'h11111111);
      tick(); @(negedge clk);
      chk("fair_r3_win_d", {2'b00, bus_a.sram_addr}, 32'h21);
      tick(); tick(); @(negedge clk);
      chk("fair_r3_dgnt", {30'h0, bus_a.d_gnt, bus_a.i_gnt}, 32'h2);
      tick(); bus_a.d_ren = 1'b0; @(negedge clk);
      chk("fair_r4_win_i", {2'b00, bus_a.sram_addr}, 32'h20);
      tick(); tick(); @(negedge clk);
      chk("fair_r4_igng", {30'h0, bus_a.d_gnt, bus_a.i_gnt}, 32'h1);
      tick(); bus_a.i_ren = 1'b0; @(negedge clk);
      chk("fair_idle", {30'h0, bus_a.d_gnt, bus_a.i_gnt}, 32'h0);
      $display("txn fair done");

      // Stores and loads on DUT A (word 0x40 starts as 0x12345678).
      a_data("st_b103",  1'b1, 1'b0, 32'h103, 2'b00, 1'b0, 32'h000000A5, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0,        1);
      a_data("ld_b103s", 1'b0, 1'b1, 32'h103, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFA5, 2);
      a_data("ld_b103u", 1'b0, 1'b1, 32'h103, 2'b00, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h000000A5, 2);
      a_data("st_h102",  1'b1, 1'b0, 32'h102, 2'b01, 1'b0, 32'h0000BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0,        1);
      a_data("ld_h102s", 1'b0, 1'b1, 32'h102, 2'b01, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFBEEF, 2);
      a_data("ld_h102u", 1'b0, 1'b1, 32'h102, 2'b01, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0000BEEF, 2);
      a_data("ld_w100",  1'b0, 1'b1, 32'h100, 2'b10, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hBEEF5678, 2);
      a_data("ld_b101s", 1'b0, 1'b1, 32'h101, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h00000056, 2);
      a_data("ld_h003",  1'b0, 1'b1, 32'h003, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
      a_data("st_w006",  1'b1, 1'b0, 32'h006, 2'b10, 1'b0, 32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
      a_data("rw_w104",  1'b1, 1'b1, 32'h104, 2'b11, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0,        1);
      a_data("ld_w104",  1'b0, 1'b1, 32'h104, 2'b10, 1'b1, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        1'b0, 32'hCAFEF00D, 2);

      // DUT B, FAIR=0 and READ_LAT=4: back-to-back data starves the instruction.
      tick();
      bus_b.i_ren = 1'b1; bus_b.i_addr = 32'hC0;
      bus_b.d_ren = 1'b1; bus_b.d_addr = 32'hC4; bus_b.d_size = 2'b10;
      @(negedge clk);
      chk("nf_r1_win_d", {2'b00, bus_b.sram_addr}, 32'h31);
      repeat (3) tick();
      @(negedge clk);
      chk("nf_c3_nognt", {30'h0, bus_b.d_gnt, bus_b.i_gnt}, 32'h0);
      tick(); @(negedge clk);
      chk("nf_c4_dgnt", {30'h0, bus_b.d_gnt, bus_b.i_gnt}, 32'h2);
      chk("nf_c4_rdata", bus_b.d_rdata, 32'h44444444);
      tick(); @(negedge clk);
      chk("nf_r2_win_d", {2'b00, bus_b.sram_addr}, 32'h31);
      repeat (4) tick();
      @(negedge clk);
      chk("nf_r2_dgnt", {30'h0, bus_b.d_gnt, bus_b.i_gnt}, 32'h2);
      tick(); bus_b.d_ren = 1'b0; @(negedge clk);
      chk("nf_r3_win_i", {2'b00, bus_b.sram_addr}, 32'h30);
      repeat (4) tick();
      @(negedge clk);
      chk("nf_r3_igng", {30'h0, bus_b.d_gnt, bus_b.i_gnt}, 32'h1);
      chk("nf_r3_irdata", bus_b.i_rdata, 32'h33333333);
      tick(); bus_b.i_ren = 1'b0;
      $display("txn nofair done");

      // Reset during an in-flight READ_LAT=4 read: no grant ever appears.
      tick();
      bus_b.d_ren = 1'b1; bus_b.d_addr = 32'hC4; bus_b.d_size = 2'b10;
      @(negedge clk);
      chk("rr_issue", {31'h0, bus_b.sram_ren}, 32'h1);
      tick(); tick();
      n_rst = 1'b0;
      @(negedge clk);
      chk("rr_c2_outs", {28'h0, bus_b.d_gnt, bus_b.i_gnt, bus_b.sram_ren, bus_b.sram_wen}, 32'h0);
      chk("rr_c2_addr", {2'b00, bus_b.sram_addr}, 32'h0);
      chk("rr_c2_rdata", bus_b.d_rdata | bus_b.i_rdata, 32'h0);
      for (int c = 3; c <= 4; c++) begin
         tick(); @(negedge clk);
         chk("rr_hold_nognt", {31'h0, bus_b.d_gnt}, 32'h0);
      end
      tick();
      bus_b.d_ren = 1'b0;
      n_rst = 1'b1;
      for (int c = 5; c <= 7; c++) begin
         @(negedge clk);
         chk("rr_post_nognt", {30'h0, bus_b.d_gnt, bus_b.i_gnt}, 32'h0);
         tick();
      end
      bus_b.i_ren = 1'b1; bus_b.i_addr = 32'hC0;
      @(negedge clk);
      chk("rr_new_issue", {2'b00, bus_b.sram_addr}, 32'h30);
      repeat (3) tick();
      @(negedge clk);
      chk("rr_new_c3", {31'h0, bus_b.i_gnt}, 32'h0);
      tick(); @(negedge clk);
      chk("rr_new_c4", {31'h0, bus_b.i_gnt}, 32'h1);
      chk("rr_new_rdata", bus_b.i_rdata, 32'h33333333);
      tick(); bus_b.i_ren = 1'b0;
      $display("txn reset_inflight done");

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dyt_mem_arbiter.md
# dyt_mem_arbiter

Parametrised two-requester SRAM arbiter and load/store aligner: the successor to the fixed 2-cycle LSU front-end. It sits between the fetch and memory stages and the single-port synchronous SRAM. It serialises instruction reads, data reads and data writes onto one SRAM port with configurable read latency. It adds fairness, byte-lane stores, sign/zero-extended sub-word loads and misalignment errors.

## Interface
Parameters:
- ADDR_W, 32, byte address width; SRAM word address is addr[ADDR_W-1:2]
- READ_LAT, 2, SRAM read latency in cycles from ren to valid rdata; legal 1..4
- FAIR, 1, 1 = instruction wins the next contested arbitration after a data grant; 0 = data always wins

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- i_ren  in  1  instruction read request; held until i_gnt
- i_addr  in  ADDR_W  instruction byte address; bits [1:0] ignored
- i_gnt  out  1  one-cycle grant; i_rdata valid this cycle
- i_rdata  out  32  fetched word; 0 when i_gnt=0
- d_ren, d_wen  in  1 each  data read / write request; held until d_gnt; d_wen wins if both are set
- d_addr  in  ADDR_W  data byte address
- d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- d_unsigned  in  1  zero-extend sub-word loads
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  one-cycle grant for read, write or error
- d_err  out  1  with d_gnt: misaligned access, nothing issued
- d_rdata  out  32  extended load data; 0 unless d_gnt and a read
- sram_addr  out  ADDR_W-2  word address
- sram_ren, sram_wen  out  1 each  one-cycle strobes
- sram_be  out  4  byte enables for the write
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  read data, valid READ_LAT cycles after sram_ren

## Operation
- FSM states: IDLE, RD_WAIT, WR_DONE, ERR.
- IDLE arbitration:
  - Candidates are the data request (d_ren|d_wen) and the instruction request (i_ren).
  - Winner is data, unless FAIR=1, last_d=1 and i_ren=1.
  - Winner's address, size, unsigned flag and owner are latched.
- Misaligned data access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No SRAM strobe; go to ERR.
  - ERR: d_gnt=1, d_err=1, then IDLE.
- Write issue (IDLE):
  - sram_wen=1 with address, be and wdata driven combinationally; go to WR_DONE.
  - WR_DONE: d_gnt=1, then IDLE.
- Read issue (IDLE):
  - sram_ren=1 combinationally; counter loaded with READ_LAT-1; go to RD_WAIT.
  - RD_WAIT holds sram_addr at the latched value and decrements the counter.
  - At count 0, sram_rdata is valid: assert the owner's gnt with aligned data, then IDLE.
- last_d: set on any d_gnt, cleared on i_gnt, reset 0.
- Store lanes, with off=addr[1:0]:
  - Byte: be=4'b0001<<off, wdata={4{b}}.
  - Half: be=4'b0011<<off, wdata={2{h}}.
  - Word: be=4'hF, wdata unchanged.
- Load: shift sram_rdata right by 8*off, then sign- or zero-extend at 8/16 bits per d_size and d_unsigned.
- Idle drive: in IDLE with no request, sram_addr=0, be=0, wdata=0.

## Timing
- Reset (async, any state):
  - State IDLE, counter 0, last_d 0.
  - All gnt/err/strobe/be outputs 0; rdata outputs 0.
  - An in-flight read is discarded; no grant follows.
- Read: request seen in IDLE at cycle 0 → gnt at cycle READ_LAT. Next arbitration at cycle READ_LAT+1.
- Write: issue at cycle 0, d_gnt at cycle 1. Misaligned access: d_gnt+d_err at cycle 1.
- Grants never overlap; at most one SRAM strobe per issue.
- A request dropped before its grant is protocol-illegal. After issue, the latched copy is used, so results are unaffected.
- The requester may present a new request in the cycle after its grant.

## Test plan
- READ_LAT=2, i_ren=1, i_addr=0x40, SRAM word 0xDEADBEEF at 0x10 → sram_ren at cycle 0 with sram_addr=0x10; i_gnt at cycle 2 with i_rdata=0xDEADBEEF.
- Simultaneous i_ren and d_ren, FAIR=1:
  - Data granted first.
  - Instruction granted next.
  - A second contested round grants data first again.
  - With FAIR=0 and back-to-back d_ren, the instruction waits until d_ren drops.
- Byte store d_addr=0x103, d_wdata=0x000000A5 → sram_be=4'b1000, sram_wdata=0xA5A5A5A5, d_gnt at cycle 1. Signed byte load of the same address returns 0xFFFFFFA5; with d_unsigned=1 it returns 0x000000A5.
- Half load at d_addr=0x3 → no sram_ren; d_gnt=1 and d_err=1 at cycle 1. Word store at 0x6 → same, with sram_wen never asserted.
- READ_LAT=4 → gnt exactly at cycle 4. Assert n_rst low at cycle 2 → no grant at all, all outputs 0; the next request after reset behaves normally.
- d_ren and d_wen both set → single write issued, no SRAM read.
